// File: rtl/lattuino_spm_pkg.sv
// Shared command and state encodings for the Lattuino self-programming controller.
package lattuino_spm_pkg;

  typedef enum logic [1:0] {
    SPM_FILL  = 2'b00,
    SPM_ERASE = 2'b01,
    SPM_WRITE = 2'b10,
    SPM_CLEAR = 2'b11
  } spm_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ERASE = 2'b01,
    ST_WRITE = 2'b10
  } spm_state_e;

endpackage

// File: rtl/lattuino_spm_pagebuf.sv
// One-page temporary buffer: word array plus valid mask; unfilled words read as the erase value.
module lattuino_spm_pagebuf
  import lattuino_spm_pkg::*;
#(
  parameter int unsigned        WORD_SIZE = 16,
  parameter int unsigned        PAGE_W    = 6,
  parameter logic [WORD_SIZE-1:0] ERASE_VAL = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [PAGE_W-1:0]    waddr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [PAGE_W-1:0]    raddr_i,
  output logic [WORD_SIZE-1:0] rdata_o,
  input  logic                 clr_word_i,
  input  logic [PAGE_W-1:0]    clr_addr_i,
  input  logic                 clr_all_i
);

  localparam int unsigned DEPTH = 1 << PAGE_W;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;

  // Data words carry no reset; the valid mask alone decides what is meaningful.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (clr_all_i) begin
      valid_d = '0;
    end
    if (clr_word_i) begin
      valid_d[clr_addr_i] = 1'b0;
    end
    if (we_i) begin
      valid_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rdata_o = valid_q[raddr_i] ? mem_q[raddr_i] : ERASE_VAL;

endmodule

// File: rtl/lattuino_spm_ctrl.sv
// SPM controller: buffers FILL data, then erases or writes one PM page a word per clock;
// forwards the CPU fetch address to the PM while idle.
module lattuino_spm_ctrl
  import lattuino_spm_pkg::*;
#(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          ADDR_W     = 13,
  parameter int unsigned          PAGE_W     = 6,
  parameter int unsigned          BOOT_START = 7680,
  parameter logic [WORD_SIZE-1:0] ERASE_VAL  = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spm_req_i,
  input  logic [1:0]           spm_cmd_i,
  input  logic [ADDR_W-1:0]    z_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic                 pm_we_o,
  output logic [WORD_SIZE-1:0] pm_data_o
);

  localparam int unsigned PG_W = ADDR_W - PAGE_W;

  spm_state_e          state_q, state_d;
  logic [PAGE_W-1:0]   cnt_q, cnt_d;
  logic [PG_W-1:0]     page_q, page_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  spm_cmd_e             cmd;
  logic                 protected_c;
  logic                 last_c;
  logic                 fill_we;
  logic                 clr_word;
  logic                 clr_all;
  logic [WORD_SIZE-1:0] buf_rdata;

  assign cmd         = spm_cmd_e'(spm_cmd_i);
  assign protected_c = 32'(z_i) >= BOOT_START;
  assign last_c      = (cnt_q == {PAGE_W{1'b1}});

  lattuino_spm_pagebuf #(
    .WORD_SIZE (WORD_SIZE),
    .PAGE_W    (PAGE_W),
    .ERASE_VAL (ERASE_VAL)
  ) u_pagebuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (fill_we),
    .waddr_i    (z_i[PAGE_W-1:0]),
    .wdata_i    (data_i),
    .raddr_i    (cnt_q),
    .rdata_o    (buf_rdata),
    .clr_word_i (clr_word),
    .clr_addr_i (cnt_q),
    .clr_all_i  (clr_all)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      page_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: command decode when idle, page sweep when busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (spm_req_i && (cmd == SPM_ERASE || cmd == SPM_WRITE)) begin
          if (protected_c) begin
            err_d = 1'b1;
          end else begin
            page_d  = z_i[ADDR_W-1:PAGE_W];
            cnt_d   = '0;
            state_d = (cmd == SPM_ERASE) ? ST_ERASE : ST_WRITE;
          end
        end
      end
      ST_ERASE, ST_WRITE: begin
        cnt_d = cnt_q + PAGE_W'(1);
        err_d = spm_req_i;
        if (last_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PM port mux and buffer strobes.
  always_comb begin
    pm_addr_o = cpu_addr_i;
    pm_we_o   = 1'b0;
    pm_data_o = ERASE_VAL;
    fill_we   = 1'b0;
    clr_word  = 1'b0;
    clr_all   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        fill_we = spm_req_i && (cmd == SPM_FILL);
        clr_all = spm_req_i && (cmd == SPM_CLEAR);
      end
      ST_ERASE: begin
        pm_we_o   = 1'b1;
        pm_addr_o = {page_q, cnt_q};
      end
      ST_WRITE: begin
        pm_we_o   = 1'b1;
        pm_addr_o = {page_q, cnt_q};
        pm_data_o = buf_rdata;
        clr_word  = 1'b1;
      end
      default: begin
        pm_we_o = 1'b0;
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_lattuino_spm_ctrl.sv
// Bench for lattuino_spm_ctrl: a page-level model checked every cycle plus literal PM content checks.
module tb_lattuino_spm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  cmd;
  logic [12:0] z;
  logic [15:0] data;
  logic [12:0] cpu_addr;
  logic        busy_o, done_o, err_o, pm_we_o;
  logic [12:0] pm_addr_o;
  logic [15:0] pm_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lattuino_spm_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .spm_req_i  (req),
    .spm_cmd_i  (cmd),
    .z_i        (z),
    .data_i     (data),
    .cpu_addr_i (cpu_addr),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .pm_addr_o  (pm_addr_o),
    .pm_we_o    (pm_we_o),
    .pm_data_o  (pm_data_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Program memory behind the controller, with a bench-side preload port.
  logic [15:0] pm [8192];
  logic        pl_en;
  int          pl_base;
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 96; i++) pm[pl_base + i] <= 16'h5555;
    end else if (pm_we_o) begin
      pm[pm_addr_o] <= pm_data_o;
    end
  end

  int n_busy = 0, n_done = 0, n_err = 0, n_we = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o)  n_busy++;
      if (done_o)  n_done++;
      if (err_o)   n_err++;
      if (pm_we_o) n_we++;
    end
  end

  // Page-level model: a busy operation is "64 cycles left, sweeping word index".
  logic [15:0] m_buf [64];
  bit          m_val [64];
  int          m_left, m_idx, m_page;
  bit          m_write, m_done, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_idx = 0; m_page = 0; m_write = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < 64; i++) m_val[i] = 0;
    end else begin
      bit nd, ne;
      nd = 0; ne = 0;
      if (m_left > 0) begin
        if (m_write) m_val[m_idx] = 0;
        m_idx++;
        m_left--;
        if (m_left == 0) nd = 1;
        if (req) ne = 1;
      end else if (req) begin
        case (cmd)
          2'b00: begin m_buf[int'(z) % 64] = data; m_val[int'(z) % 64] = 1; end
          2'b11: for (int i = 0; i < 64; i++) m_val[i] = 0;
          default: begin
            if (int'(z) >= 7680) ne = 1;
            else begin
              m_left = 64; m_idx = 0; m_page = int'(z) / 64; m_write = (cmd == 2'b10);
            end
          end
        endcase
      end
      m_done = nd;
      m_err  = ne;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic        eb;
      logic [12:0] ea;
      logic [15:0] ed;
      eb = (m_left > 0);
      ea = eb ? 13'(m_page * 64 + m_idx) : cpu_addr;
      ed = (eb && m_write && m_val[m_idx % 64]) ? m_buf[m_idx % 64] : 16'hFFFF;
      chk("busy", 32'(busy_o), 32'(eb));
      chk("pm_we", 32'(pm_we_o), 32'(eb));
      chk("pm_addr", 32'(pm_addr_o), 32'(ea));
      chk("pm_data", 32'(pm_data_o), 32'(ed));
      chk("done", 32'(done_o), 32'(m_done));
      chk("err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic spm(input logic [1:0] c, input logic [12:0] zz, input logic [15:0] d);
    @(posedge clk); #1;
    req = 1'b1; cmd = c; z = zz; data = d;
    @(posedge clk); #1;
    req = 1'b0; cmd = 2'b00; z = 13'h1FFF; data = 16'hDEAD;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 32'(busy_o), 32'h0);
  endtask

  task automatic page_bad(input int base, input logic [15:0] v, output int bad);
    bad = 0;
    for (int i = 0; i < 64; i++) if (pm[base + i] !== v) bad++;
  endtask

  initial begin
    int b0, d0, e0, w0, bad;
    rst_n = 1'b0; req = 1'b0; cmd = 2'b00; z = '0; data = '0;
    cpu_addr = 13'h0ABC; pl_en = 1'b0; pl_base = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_we", 32'(pm_we_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_addr_pass", 32'(pm_addr_o), 32'h0ABC);
    rst_n = 1'b1;

    // FILL two words then WRITE page 1.
    spm(2'b00, 13'h0040, 16'h1234);
    spm(2'b00, 13'h0041, 16'hABCD);
    cpu_addr = 13'h0123;
    b0 = n_busy; d0 = n_done;
    spm(2'b10, 13'h0040, 16'h0);
    wait_idle("write1");
    @(negedge clk);
    chk("w1_busy_cycles", 32'(n_busy - b0), 32'd64);
    chk("w1_done_pulses", 32'(n_done - d0), 32'd1);
    chk("w1_pm40", 32'(pm[13'h040]), 32'h1234);
    chk("w1_pm41", 32'(pm[13'h041]), 32'hABCD);
    bad = 0;
    for (int i = 'h42; i <= 'h7F; i++) if (pm[i] !== 16'hFFFF) bad++;
    chk("w1_rest_ffff", 32'(bad), 32'd0);

    // Preload 0x70..0xCF, erase the page holding 0x95.
    @(posedge clk); #1; pl_base = 'h70; pl_en = 1'b1;
    @(posedge clk); #1; pl_en = 1'b0;
    spm(2'b01, 13'h0095, 16'h0);
    wait_idle("erase");
    page_bad('h80, 16'hFFFF, bad);
    chk("erase_page", 32'(bad), 32'd0);
    chk("erase_below", 32'(pm[13'h07F]), 32'h5555);
    chk("erase_above", 32'(pm[13'h0C0]), 32'h5555);

    // Protected boot section.
    w0 = n_we; e0 = n_err; b0 = n_busy;
    spm(2'b10, 13'h1E00, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("boot_err", 32'(n_err - e0), 32'd1);
    chk("boot_no_we", 32'(n_we - w0), 32'd0);
    chk("boot_no_busy", 32'(n_busy - b0), 32'd0);

    // Requests during a WRITE are rejected and leave the buffer alone.
    spm(2'b00, 13'h0100, 16'h1111);
    e0 = n_err;
    spm(2'b10, 13'h0100, 16'h0);
    repeat (9) @(posedge clk);
    #1;
    spm(2'b00, 13'h0101, 16'h2222);
    spm(2'b01, 13'h0140, 16'h0);
    wait_idle("write_busy");
    chk("busy_rej_err", 32'(n_err - e0), 32'd2);
    chk("busy_pm100", 32'(pm[13'h100]), 32'h1111);
    chk("busy_pm101", 32'(pm[13'h101]), 32'hFFFF);
    spm(2'b10, 13'h0140, 16'h0);
    wait_idle("write_empty");
    page_bad('h140, 16'hFFFF, bad);
    chk("empty_write_page", 32'(bad), 32'd0);

    // Reset in the middle of a WRITE to page 2.
    spm(2'b00, 13'h0080, 16'hBEEF);
    spm(2'b10, 13'h0080, 16'h0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(pm_we_o), 32'h0);
    chk("abort_busy", 32'(busy_o), 32'h0);
    chk("abort_partial", 32'(pm[13'h080]), 32'hBEEF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    spm(2'b10, 13'h0080, 16'h0);
    wait_idle("post_abort");
    chk("abort_mask_clr", 32'(pm[13'h080]), 32'hFFFF);

    // CLEAR drops earlier FILLs only.
    spm(2'b00, 13'h0185, 16'h0001);
    spm(2'b11, 13'h0000, 16'h0);
    spm(2'b00, 13'h0186, 16'h0002);
    spm(2'b10, 13'h0180, 16'h0);
    wait_idle("clear");
    chk("clear_off5", 32'(pm[13'h185]), 32'hFFFF);
    chk("clear_off6", 32'(pm[13'h186]), 32'h0002);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
